sprite_fetch_arbiter: RTL and testbench

Shares one synchronous sprite ROM (1-cycle read latency, same ROM/palette style as the background renderer) among several sprite engines (tanks, bullets, HUD). Each requester asks for a burst of consecutive ROM words. The arbiter picks one requester round-robin, sequences the burst addresses into the ROM, and returns the data stream tagged with the requester ID. It sits between the sprite engines and the single ROM instance in the VGA clock domain.

---
 rtl/sprite_fetch_arbiter_pkg.sv | 19 +
 rtl/sprite_fetch_arbiter_if.sv | 37 +++
 rtl/sprite_fetch_arbiter_rr.sv | 34 +++
 rtl/sprite_fetch_arbiter.sv | 118 +++++++++++
 tb/tb_sprite_fetch_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_fetch_arbiter_pkg.sv
// Shared types and defaults for the sprite ROM fetch arbiter.
package sprite_fetch_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 4;
  localparam int DEF_LEN_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } fetch_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_fetch_arbiter_if.sv
// Bundle of request, ROM and response signals between the sprite engines,
// the sprite ROM and the fetch arbiter.
interface sprite_fetch_arbiter_if
  import sprite_fetch_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W
);
  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_base;
  logic [NUM_REQ*LEN_W-1:0]  req_len_m1;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_last;
  logic [DATA_W-1:0]         rsp_data;

  // Engine/ROM side: issues requests and returns ROM data.
  modport master (
    output req, req_base, req_len_m1, rom_q,
    input  gnt, busy, rom_address, rsp_valid, rsp_id, rsp_last, rsp_data
  );

  // Arbiter side.
  modport slave (
    input  req, req_base, req_len_m1, rom_q,
    output gnt, busy, rom_address, rsp_valid, rsp_id, rsp_last, rsp_data
  );

endinterface

// File: rtl/sprite_fetch_arbiter_rr.sv
// Combinational round-robin pick: first requester at or above the pointer,
// wrapping around to zero.
module rr_arbiter
  import sprite_fetch_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [ID_W-1:0]    win_idx,
  output logic               win_any
);

  int cand;

  // Scan from the pointer upward and keep the first requester found.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_any    = 1'b0;
    cand       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!win_any && req[cand]) begin
        win_any          = 1'b1;
        win_onehot[cand] = 1'b1;
        win_idx          = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Shares the single sprite ROM among the sprite engines: grants one burst at
// a time round-robin, walks the burst addresses into the ROM and tags the
// returned words with the owner's ID.
module sprite_fetch_arbiter
  import sprite_fetch_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  parameter int  ADDR_W  = DEF_ADDR_W,
  parameter int  DATA_W  = DEF_DATA_W,
  parameter int  LEN_W   = DEF_LEN_W,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input logic                  vga_clk,
  input logic                  reset,
  sprite_fetch_arbiter_if.slave bus
);

  fetch_state_e       state, state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    next_ptr;
  logic [NUM_REQ-1:0] win_onehot;
  logic [ID_W-1:0]    win_idx;
  logic               win_any;
  logic [ADDR_W-1:0]  win_base;
  logic [LEN_W-1:0]   win_len;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [LEN_W-1:0]   remain;
  logic [ID_W-1:0]    burst_id;
  logic               accept;
  logic               issuing;
  logic               burst_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req),
    .ptr        (ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

  assign win_base = bus.req_base[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_len  = bus.req_len_m1[int'(win_idx)*LEN_W +: LEN_W];
  assign next_ptr = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);

  assign bus.busy     = issuing;
  assign bus.rsp_data = bus.rom_q;

  // FSM state register.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant in IDLE straight from req; in BURST leave once the last word issues.
  always_comb begin
    state_nxt  = state;
    bus.gnt    = '0;
    accept     = 1'b0;
    issuing    = 1'b0;
    burst_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_any) begin
          bus.gnt   = win_onehot;
          accept    = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        issuing = 1'b1;
        if (remain == '0) begin
          burst_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On accept the first address goes straight to the ROM so the burst starts
  // the next cycle; afterwards each issued word advances the counters.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      ptr             <= '0;
      addr_cnt        <= '0;
      remain          <= '0;
      burst_id        <= '0;
      bus.rom_address <= '0;
    end else if (accept) begin
      ptr             <= next_ptr;
      addr_cnt        <= win_base + ADDR_W'(1);
      remain          <= win_len;
      burst_id        <= win_idx;
      bus.rom_address <= win_base;
    end else if (issuing && !burst_done) begin
      addr_cnt        <= addr_cnt + ADDR_W'(1);
      remain          <= remain - LEN_W'(1);
      bus.rom_address <= addr_cnt;
    end
  end

  // Response flags trail the issue stage by one cycle to line up with rom_q.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_last  <= 1'b0;
    end else begin
      bus.rsp_valid <= issuing;
      bus.rsp_id    <= burst_id;
      bus.rsp_last  <= burst_done;
    end
  end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Scoreboard bench for sprite_fetch_arbiter: directed bursts push expected
// response words, a negedge monitor pops and compares each valid word.
module tb_sprite_fetch_arbiter;
  import sprite_fetch_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 4;
  localparam int LEN_W   = 5;
  localparam int ID_W    = id_w(NUM_REQ);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              last;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic vga_clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_exp;

  logic [NUM_REQ-1:0] contention_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [ADDR_W-1:0]  wrap_addr [4]      = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

  sprite_fetch_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) bus ();

  sprite_fetch_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 vga_clk = ~vga_clk;

  // ROM model: one-cycle latency, word equals the low address bits.
  always @(posedge vga_clk) bus.rom_q <= bus.rom_address[DATA_W-1:0];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic apply_stimulus(input int idx, input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len_m1);
    bus.req_base[idx*ADDR_W +: ADDR_W]  = base;
    bus.req_len_m1[idx*LEN_W +: LEN_W]  = len_m1;
    bus.req[idx]                        = 1'b1;
  endtask

  task automatic push_burst(input int id, input logic [ADDR_W-1:0] base, input int len_m1, input int n_words);
    exp_t e;
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < n_words; k++) begin
      a      = base + ADDR_W'(k);
      e.id   = ID_W'(id);
      e.last = (k == len_m1);
      e.data = a[DATA_W-1:0];
      sb.push_back(e);
    end
  endtask

  // Monitor: every valid response word must match the head of the scoreboard.
  always @(negedge vga_clk) begin
    if (reset === 1'b0 && bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp_unexpected: got word id=%0d data=0x%0h, required no rsp_valid at %0t",
                 bus.rsp_id, bus.rsp_data, $time);
      end else begin
        mon_exp = sb.pop_front();
        check_output("rsp_id", 32'(bus.rsp_id), 32'(mon_exp.id));
        check_output("rsp_last", 32'(bus.rsp_last), 32'(mon_exp.last));
        check_output("rsp_data", 32'(bus.rsp_data), 32'(mon_exp.data));
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.req        = '0;
    bus.req_base   = '0;
    bus.req_len_m1 = '0;
    #12;
    check_output("reset_gnt", 32'(bus.gnt), 0);
    check_output("reset_busy", 32'(bus.busy), 0);
    check_output("reset_rom_address", 32'(bus.rom_address), 0);
    check_output("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check_output("reset_rsp_id", 32'(bus.rsp_id), 0);
    check_output("reset_rsp_last", 32'(bus.rsp_last), 0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    $display("[TB] contention, all four requesting single words");
    for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, ADDR_W'(10'h101 + 10'h011 * i), '0);
    push_burst(0, 10'h101, 0, 1);
    push_burst(1, 10'h112, 0, 1);
    push_burst(2, 10'h123, 0, 1);
    push_burst(3, 10'h134, 0, 1);
    push_burst(0, 10'h101, 0, 1);
    for (int g = 0; g < 5; g++) begin
      @(negedge vga_clk);
      check_output("contention_gnt", 32'(bus.gnt), 32'(contention_gnt[g]));
      next_cycle();
      if (g == 4) bus.req = '0;
      @(negedge vga_clk);
      check_output("contention_gnt_in_burst", 32'(bus.gnt), 0);
      next_cycle();
    end
    repeat (3) next_cycle();

    $display("[TB] single burst from requester 2");
    apply_stimulus(2, 10'h040, 5'd3);
    push_burst(2, 10'h040, 3, 4);
    @(negedge vga_clk);
    check_output("single_gnt", 32'(bus.gnt), 32'h4);
    next_cycle();
    bus.req = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge vga_clk);
      check_output("single_rom_address", 32'(bus.rom_address), 32'h040 + 32'(k));
      check_output("single_busy", 32'(bus.busy), 1);
      next_cycle();
    end
    @(negedge vga_clk);
    check_output("single_busy_after", 32'(bus.busy), 0);
    repeat (2) next_cycle();

    $display("[TB] address wrap from requester 3");
    apply_stimulus(3, 10'h3FE, 5'd3);
    push_burst(3, 10'h3FE, 3, 4);
    @(negedge vga_clk);
    check_output("wrap_gnt", 32'(bus.gnt), 32'h8);
    next_cycle();
    bus.req = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge vga_clk);
      check_output("wrap_rom_address", 32'(bus.rom_address), 32'(wrap_addr[k]));
      next_cycle();
    end
    repeat (2) next_cycle();

    $display("[TB] granted requester changes fields mid-burst, requester 0 waits");
    apply_stimulus(1, 10'h200, 5'd3);
    push_burst(1, 10'h200, 3, 4);
    @(negedge vga_clk);
    check_output("ignore_gnt1", 32'(bus.gnt), 32'h2);
    next_cycle();
    bus.req_base[1*ADDR_W +: ADDR_W] = 10'h0F0;
    bus.req_len_m1[1*LEN_W +: LEN_W] = 5'd7;
    bus.req = '0;
    apply_stimulus(0, 10'h0A0, 5'd0);
    push_burst(0, 10'h0A0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge vga_clk);
      check_output("ignore_rom_address", 32'(bus.rom_address), 32'h200 + 32'(k));
      check_output("ignore_gnt_in_burst", 32'(bus.gnt), 0);
      next_cycle();
    end
    @(negedge vga_clk);
    check_output("ignore_gnt0", 32'(bus.gnt), 32'h1);
    check_output("ignore_rsp_last", 32'(bus.rsp_last), 1);
    next_cycle();
    bus.req = '0;
    @(negedge vga_clk);
    check_output("ignore_rom_address0", 32'(bus.rom_address), 32'h0A0);
    repeat (3) next_cycle();

    $display("[TB] reset during a 32-word burst");
    apply_stimulus(2, 10'h010, 5'd31);
    push_burst(2, 10'h010, 31, 10);
    @(negedge vga_clk);
    check_output("midreset_gnt", 32'(bus.gnt), 32'h4);
    next_cycle();
    bus.req = '0;
    repeat (11) next_cycle();
    #1;
    reset = 1'b1;
    #1;
    check_output("midreset_rsp_valid_async", 32'(bus.rsp_valid), 0);
    check_output("midreset_busy_async", 32'(bus.busy), 0);
    check_output("midreset_sb_drained", 32'(sb.size()), 0);
    repeat (2) next_cycle();
    reset = 1'b0;
    @(negedge vga_clk);
    check_output("postreset_gnt", 32'(bus.gnt), 0);
    check_output("postreset_busy", 32'(bus.busy), 0);
    check_output("postreset_rom_address", 32'(bus.rom_address), 0);
    check_output("postreset_rsp_valid", 32'(bus.rsp_valid), 0);
    check_output("postreset_rsp_id", 32'(bus.rsp_id), 0);
    check_output("postreset_rsp_last", 32'(bus.rsp_last), 0);
    repeat (3) next_cycle();
    apply_stimulus(1, 10'h155, 5'd1);
    apply_stimulus(3, 10'h300, 5'd0);
    push_burst(1, 10'h155, 1, 2);
    @(negedge vga_clk);
    check_output("postreset_first_gnt", 32'(bus.gnt), 32'h2);
    next_cycle();
    bus.req = '0;

    for (int w = 0; w < 50 && sb.size() != 0; w++) next_cycle();
    repeat (3) next_cycle();
    check_output("scoreboard_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
